// File: rtl/key_sched_seq_if.sv
// rtl/key_sched_seq_if.sv - start/status handshake and round-key read bus of key_sched_seq
//
// Signals:
//   start      master->slave  request expansion of key_in
//   key_in     master->slave  256-bit MSB-aligned cipher key
//   rd_idx     master->slave  round-key index
//   busy       slave->master  expansion in progress
//   done       slave->master  one-cycle pulse after the last word is written
//   key_ready  slave->master  store holds a complete schedule
//   rd_key     slave->master  registered round key for rd_idx
//   zeroize    master->slave  clear key material (KEYSCHED_ZEROIZE_EN only)
interface key_sched_seq_if;
   logic         start;
   logic [255:0] key_in;
   logic         busy;
   logic         done;
   logic         key_ready;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;
`ifdef KEYSCHED_ZEROIZE_EN
   logic         zeroize;

   modport master (output start, key_in, rd_idx, zeroize,
                   input  busy, done, key_ready, rd_key);
   modport slave  (input  start, key_in, rd_idx, zeroize,
                   output busy, done, key_ready, rd_key);
`else
   modport master (output start, key_in, rd_idx,
                   input  busy, done, key_ready, rd_key);
   modport slave  (input  start, key_in, rd_idx,
                   output busy, done, key_ready, rd_key);
`endif
endinterface

// File: rtl/key_sched_seq.sv
// rtl/key_sched_seq.sv - sequential AES key expansion, one schedule word per cycle
//
// sbox: AES S-box, computed as GF(2^8) inverse (x^254) followed by the affine map.
//   a  input  8  byte in
//   y  output 8  substituted byte
//
// key_sched_seq: expands a 128/192/256-bit key (NK = 4/6/8) into NR+1 round keys.
//   clk  input   rising-edge clock
//   rst  input   synchronous active-high reset
//   ks   slave   key_sched_seq_if: start/key_in/rd_idx in, busy/done/key_ready/rd_key out
// Optional feature macro: KEYSCHED_ZEROIZE_EN adds ks.zeroize, which clears
// all key material and aborts an expansion exactly like rst.
module sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = x;
      for (int n = 0; n < 8; n++) begin
         if (b[n]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

   // Addition chain to x^254; 0 maps to 0 as AES requires.
   always_comb begin
      x2   = gmul(a, a);
      x3   = gmul(x2, a);
      x6   = gmul(x3, x3);
      x7   = gmul(x6, a);
      x14  = gmul(x7, x7);
      x15  = gmul(x14, a);
      x30  = gmul(x15, x15);
      x31  = gmul(x30, a);
      x62  = gmul(x31, x31);
      x63  = gmul(x62, a);
      x126 = gmul(x63, x63);
      x127 = gmul(x126, a);
      inv  = gmul(x127, x127);
      y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module key_sched_seq #(
   parameter int NK = 4
) (
   input logic      clk,
   input logic      rst,
   key_sched_seq_if.slave ks
);
   localparam int NR = NK + 6;
   localparam int TW = 4 * (NR + 1);
   localparam logic [5:0] I_FIRST = 6'(NK);
   localparam logic [5:0] I_LAST  = 6'(TW - 1);
   localparam logic [2:0] K_LAST  = 3'(NK - 1);
   localparam logic [3:0] R_LAST  = 4'(NR);

   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nxt;

   logic [31:0]  win [0:NK-1];   // win[0] = w[i-NK] ... win[NK-1] = w[i-1]
   logic [31:0]  sw  [0:TW-1];   // key store, word-addressed
   logic [5:0]   i;              // index of the next word to generate
   logic [2:0]   kpos;           // i mod NK, kept as a counter
   logic [7:0]   rcon;           // Rcon[i/NK] for the next i mod NK = 0 word
   logic         done_r;
   logic         key_ready_r;
   logic [127:0] rd_key_r;
   logic [3:0]   row;

   logic         clear, accept, step, finish;
   logic [31:0]   prev, sub_in, sub_out, temp, wnew;

`ifdef KEYSCHED_ZEROIZE_EN
   assign clear = rst | ks.zeroize;
`else
   assign clear = rst;
`endif

   // done_r gates acceptance so a start coinciding with the done pulse is dropped.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (ks.start && !done_r) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (i == I_LAST) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) state <= IDLE;
      else       state <= state_nxt;
   end

   assign prev   = win[NK-1];
   assign sub_in = (kpos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

   sbox u_sb0 (.a(sub_in[7:0]),   .y(sub_out[7:0]));
   sbox u_sb1 (.a(sub_in[15:8]),  .y(sub_out[15:8]));
   sbox u_sb2 (.a(sub_in[23:16]), .y(sub_out[23:16]));
   sbox u_sb3 (.a(sub_in[31:24]), .y(sub_out[31:24]));

   always_comb begin
      temp = prev;
      if (kpos == 3'd0)
         temp = sub_out ^ {rcon, 24'h0};
      else if (NK == 8 && kpos == 3'd4)
         temp = sub_out;
   end

   assign wnew = win[0] ^ temp;
   assign row  = (ks.rd_idx <= R_LAST) ? ks.rd_idx : 4'd0;

   always_ff @(posedge clk) begin
      if (clear) begin
         for (int k = 0; k < NK; k++) win[k] <= '0;
         for (int k = 0; k < TW; k++) sw[k]  <= '0;
         i           <= '0;
         kpos        <= '0;
         rcon        <= 8'h01;
         done_r      <= 1'b0;
         key_ready_r <= 1'b0;
         rd_key_r    <= '0;
      end else begin
         done_r   <= finish;
         rd_key_r <= (ks.rd_idx <= R_LAST)
                     ? {sw[{row, 2'b00}], sw[{row, 2'b01}], sw[{row, 2'b10}], sw[{row, 2'b11}]}
                     : '0;
         if (accept) begin
            // Wipe the previous schedule so unwritten words read as zero.
            for (int k = 0; k < TW; k++) sw[k] <= '0;
            for (int k = 0; k < NK; k++) begin
               sw[k]  <= ks.key_in[255-32*k -: 32];
               win[k] <= ks.key_in[255-32*k -: 32];
            end
            i           <= I_FIRST;
            kpos        <= 3'd0;
            rcon        <= 8'h01;
            key_ready_r <= 1'b0;
         end else if (step) begin
            sw[i] <= wnew;
            for (int k = 0; k < NK - 1; k++) win[k] <= win[k+1];
            win[NK-1] <= wnew;
            i    <= i + 6'd1;
            kpos <= (kpos == K_LAST) ? 3'd0 : kpos + 3'd1;
            if (kpos == 3'd0)
               rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            if (finish) key_ready_r <= 1'b1;
         end
      end
   end

   assign ks.busy      = (state == RUN);
   assign ks.done      = done_r;
   assign ks.key_ready = key_ready_r;
   assign ks.rd_key    = rd_key_r;
endmodule

// File: tb/tb_key_sched_seq.sv
// tb/tb_key_sched_seq.sv - self-checking bench for key_sched_seq at NK = 4, 6, 8
module tb_key_sched_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [2:0]   start_v;
   logic [255:0] key;
   logic [3:0]   rd_idx;
`ifdef KEYSCHED_ZEROIZE_EN
   logic         zer;
`endif

   key_sched_seq_if if0 ();
   key_sched_seq_if if1 ();
   key_sched_seq_if if2 ();

   assign if0.start = start_v[0];
   assign if1.start = start_v[1];
   assign if2.start = start_v[2];
   assign if0.key_in = key;
   assign if1.key_in = key;
   assign if2.key_in = key;
   assign if0.rd_idx = rd_idx;
   assign if1.rd_idx = rd_idx;
   assign if2.rd_idx = rd_idx;
`ifdef KEYSCHED_ZEROIZE_EN
   assign if0.zeroize = zer;
   assign if1.zeroize = zer;
   assign if2.zeroize = zer;
`endif

   key_sched_seq #(.NK(4)) u_dut4 (.clk(clk), .rst(rst), .ks(if0));
   key_sched_seq #(.NK(6)) u_dut6 (.clk(clk), .rst(rst), .ks(if1));
   key_sched_seq #(.NK(8)) u_dut8 (.clk(clk), .rst(rst), .ks(if2));

   logic         busy_v [0:2];
   logic         done_v [0:2];
   logic         kr_v   [0:2];
   logic [127:0] rk_v   [0:2];
   assign busy_v[0] = if0.busy;      assign busy_v[1] = if1.busy;      assign busy_v[2] = if2.busy;
   assign done_v[0] = if0.done;      assign done_v[1] = if1.done;      assign done_v[2] = if2.done;
   assign kr_v[0]   = if0.key_ready; assign kr_v[1]   = if1.key_ready; assign kr_v[2]   = if2.key_ready;
   assign rk_v[0]   = if0.rd_key;    assign rk_v[1]   = if1.rd_key;    assign rk_v[2]   = if2.rd_key;

   int checks = 0;
   int errors = 0;

   // Reference model: FIPS-197 key expansion written directly from the standard.
   logic [7:0]  sb [0:255];
   logic [7:0]  rc [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   logic [31:0] mw [0:59];

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   function automatic void model(input int nk, input logic [255:0] k);
      logic [31:0] t;
      for (int j = 0; j < nk; j++) mw[j] = k[255-32*j -: 32];
      for (int j = nk; j < 4 * (nk + 7); j++) begin
         t = mw[j-1];
         if (j % nk == 0)
            t = subw({t[23:0], t[31:24]}) ^ {rc[j/nk], 24'h0};
         else if (nk == 8 && j % 8 == 4)
            t = subw(t);
         mw[j] = mw[j-nk] ^ t;
      end
   endfunction

   function automatic logic [127:0] mrk(input int nk, input int r);
      if (r > nk + 6) return '0;
      return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
   endfunction

   function automatic int nk_of(input int d);
      return 4 + 2 * d;
   endfunction

   function automatic logic [255:0] rand256();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input int d, input int idx, output logic [127:0] v);
      rd_idx = 4'(idx);
      tick();
      v = rk_v[d];
   endtask

   task automatic chk_all(input int d, input string tag);
      logic [127:0] v;
      for (int r = 0; r < 16; r++) begin
         rd(d, r, v);
         chk($sformatf("%s r%0d", tag, r), v, mrk(nk_of(d), r));
      end
   endtask

   // Starts an expansion and returns in the cycle where done is high.
   task automatic run(input int d, input logic [255:0] k, input string tag);
      int n;
      key = k;
      start_v[d] = 1'b1;
      tick();
      start_v[d] = 1'b0;
      chk({tag, " busy"}, 128'(busy_v[d]), 128'd1);
      chk({tag, " kr_low"}, 128'(kr_v[d]), 128'd0);
      n = 0;
      while (done_v[d] !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk({tag, " cycles"}, 128'(n), 128'(3 * nk_of(d) + 28));
      chk({tag, " busy_end"}, 128'(busy_v[d]), 128'd0);
      chk({tag, " kr_end"}, 128'(kr_v[d]), 128'd1);
   endtask

   localparam logic [255:0] K128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [7:0]   p, q, x;
      logic [127:0] v;
      logic [255:0] ka, kb;
      int           pulses;

      // S-box table from the multiplicative-generator walk (3 and its inverse).
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sb[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;

      rst = 1'b1;
      start_v = '0;
      key = '0;
      rd_idx = '0;
`ifdef KEYSCHED_ZEROIZE_EN
      zer = 1'b0;
`endif
      tick();
      tick();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst busy d%0d", d), 128'(busy_v[d]), 128'd0);
         chk($sformatf("rst done d%0d", d), 128'(done_v[d]), 128'd0);
         chk($sformatf("rst kr d%0d", d), 128'(kr_v[d]), 128'd0);
         chk($sformatf("rst rdkey d%0d", d), rk_v[d], 128'd0);
      end
      rst = 1'b0;

      // Published vectors
      run(0, K128, "fips128");
      rd(0, 10, v);
      chk("fips128 r10", v, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
      rd(0, 0, v);
      chk("fips128 r0", v, K128[255:128]);
      model(4, K128);
      chk_all(0, "fips128");

      run(1, K192, "fips192");
      rd(1, 12, v);
      chk("fips192 r12", v, 128'he98ba06f_448c773c_8ecc7204_01002202);
      model(6, K192);
      chk_all(1, "fips192");

      run(2, K256, "fips256");
      rd(2, 14, v);
      chk("fips256 r14", v, 128'hfe4890d1_e6188d0b_046df344_706c631e);
      model(8, K256);
      chk_all(2, "fips256");

      // Random keys against the model
      for (int t = 0; t < 3; t++) begin
         for (int d = 0; d < 3; d++) begin
            ka = rand256();
            model(nk_of(d), ka);
            run(d, ka, $sformatf("rnd%0d d%0d", t, d));
            chk_all(d, $sformatf("rnd%0d d%0d", t, d));
         end
      end

      // Second start 10 cycles into RUN is ignored
      ka = rand256();
      kb = rand256();
      model(4, ka);
      key = ka;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      pulses = 0;
      for (int c = 0; c < 60; c++) begin
         if (c == 10) begin
            key = kb;
            start_v[0] = 1'b1;
         end
         tick();
         start_v[0] = 1'b0;
         if (done_v[0] === 1'b1) pulses++;
      end
      chk("restart pulses", 128'(pulses), 128'd1);
      chk("restart busy", 128'(busy_v[0]), 128'd0);
      chk_all(0, "restart");

      // Start coinciding with done is dropped, next cycle it is accepted
      ka = rand256();
      model(4, ka);
      run(0, ka, "pre_done");
      kb = rand256();
      key = kb;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      chk("done_start busy", 128'(busy_v[0]), 128'd0);
      chk("done_start done", 128'(done_v[0]), 128'd0);
      chk_all(0, "done_start");
      model(4, kb);
      run(0, kb, "after_done");
      chk_all(0, "after_done");

      // Reset 20 cycles into RUN aborts
      ka = rand256();
      model(4, ka);
      key = ka;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      rd(0, 0, v);
      chk("midrun r0", v, ka[255:128]);
      rd(0, 10, v);
      chk("midrun r10", v, 128'd0);
      chk("midrun kr", 128'(kr_v[0]), 128'd0);
      repeat (18) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort busy", 128'(busy_v[0]), 128'd0);
      chk("abort kr", 128'(kr_v[0]), 128'd0);
      pulses = 0;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (done_v[0] === 1'b1) pulses++;
      end
      chk("abort pulses", 128'(pulses), 128'd0);
      for (int r = 0; r < 16; r++) begin
         rd(0, r, v);
         chk($sformatf("abort r%0d", r), v, 128'd0);
      end
      run(0, ka, "post_abort");
      chk_all(0, "post_abort");
      rd(0, 15, v);
      chk("post_abort r15", v, 128'd0);

`ifdef KEYSCHED_ZEROIZE_EN
      zer = 1'b1;
      tick();
      zer = 1'b0;
      chk("zeroize kr", 128'(kr_v[0]), 128'd0);
      chk("zeroize busy", 128'(busy_v[0]), 128'd0);
      rd(0, 10, v);
      chk("zeroize r10", v, 128'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
